num_entry_seq: RTL and testbench
================================

// Module: num_entry_seq
// PURPOSE
// - Clocked successor to the combinational number maker.
// - Holds a signed BITS-wide operand register that is edited from board keys: +/-10^k step, negate, clear, load.
// - Adds key synchronisation, single-action-per-press, hold-to-auto-repeat, and saturating/wrapping overflow with a sticky flag.
// - Feeds the ALU operand input; replaces direct switch-to-number wiring.
// PARAMETERS
// - BITS      16   operand width, signed two's complement
// - DIGITS    5    number of decimal step ranges, 10^0..10^(DIGITS-1); 10^(DIGITS-1) must be < 2^(BITS-1) (elaboration $error otherwise)
// - SAT       1    1 = clamp on overflow, 0 = wrap modulo 2^BITS
// - HOLD_CYC  25000000  cycles a key is held before auto-repeat starts
// - REP_CYC   5000000   cycles between auto-repeat actions
// PORTS
// - CLK       in   1                 system clock
// - RST_N     in   1                 asynchronous, active-low reset
// - KEY_INC   in   1                 add step (active-high, asynchronous to CLK)
// - KEY_DEC   in   1                 subtract step (active-high, async)
// - KEY_NEG   in   1                 two's-complement negate (active-high, async)
// - CLR       in   1                 clear value and OVF (active-high, async)
// - LOAD      in   1                 load LOAD_VAL (active-high, async)
// - LOAD_VAL  in   BITS              value loaded on LOAD; sampled on the action cycle
// - DIG_SEL   in   $clog2(DIGITS)    step exponent k; static while a key is held
// - OUT       out  BITS              current signed value
// - CHANGED   out  1                 one-cycle pulse on every action cycle that writes OUT
// - OVF       out  1                 sticky overflow flag
// BEHAVIOUR
// - Reset (async assert, sync deassert via CLK): OUT=0, CHANGED=0, OVF=0, FSM=WAIT_REL, all sync flops=0.
// - All five key inputs pass a 2-flop synchroniser. The action is applied on the first cycle the synced level is seen high in IDLE.
//   - OUT/CHANGED register 1 cycle later: 3 CLK from input rise to OUT update.
// - FSM states: IDLE, HOLD, REPEAT, WAIT_REL.
//   - IDLE: any synced key high -> apply action once, latch winning key, go to HOLD (INC/DEC) or WAIT_REL (NEG/CLR/LOAD).
//   - HOLD: count HOLD_CYC cycles from the action. If the latched key is still high at count end -> apply, go to REPEAT; if it drops -> WAIT_REL.
//   - REPEAT: apply every REP_CYC cycles while the latched key stays high; on drop -> WAIT_REL.
//   - WAIT_REL: go to IDLE when all synced keys are low.
//   - A key held through reset release therefore does nothing until released.
// - Priority for simultaneous keys in IDLE: LOAD > CLR > NEG > INC > DEC.
//   - Losing keys are ignored until every key is released.
//   - Newly pressed keys are ignored while in HOLD/REPEAT.
// - Step = 10^DIG_SEL from a constant table. If DIG_SEL >= DIGITS, step = 0: INC/DEC produce no write, no CHANGED, no OVF.
// - Arithmetic in BITS+1 bits, then range-checked against [-2^(BITS-1), 2^(BITS-1)-1]:
//   - SAT=1: clamp to MAX/MIN, OVF<=1.
//   - SAT=0: keep low BITS bits, OVF<=1.
// - NEG of MIN overflows: SAT=1 -> MAX, SAT=0 -> MIN unchanged; OVF<=1 in both cases, CHANGED pulses.
// - CLR: OUT<=0, OVF<=0. LOAD: OUT<=LOAD_VAL, OVF<=0. Both pulse CHANGED.
// - OVF stays set until CLR, LOAD or reset.
// - Auto-repeat counter is one counter, width $clog2(max(HOLD_CYC,REP_CYC)+1), reloaded on every state entry.
// - Reset mid-hold aborts immediately; no partial action is applied.
// STRUCTURE
// - Package num_pkg:
//   - typedef enum logic [1:0] {IDLE, HOLD, REPEAT, WAIT_REL} entry_state_t
//   - typedef enum of key codes
//   - function pow10(k, BITS) building the step table
//   - MAX/MIN helper functions
// - Sub-module sync2 (2-flop synchroniser, RST_N async clear, parametric width), instantiated once for the 5 keys.
// - FSM, counter and saturating datapath stay in this module.
// TESTING (BITS=16, DIGITS=5, HOLD_CYC=4, REP_CYC=2)
// - Reset: RST_N=0 -> OUT=0, CHANGED=0, OVF=0. Release with KEY_INC held -> OUT stays 0 until release and re-press.
// - DIG_SEL=2, KEY_INC high 3 cycles -> OUT=100 exactly 3 CLK after rise; one CHANGED pulse.
// - DIG_SEL=0, KEY_INC high 12 cycles -> actions at relative cycles 0,4,6,8,10 -> OUT=5, five CHANGED pulses.
// - LOAD 32760; DIG_SEL=1 INC -> OUT=32767, OVF=1 (SAT=1), or OUT=-32766, OVF=1 (SAT=0). CLR -> OUT=0, OVF=0.
// - LOAD -32768 then NEG -> SAT=1: 32767, OVF=1; SAT=0: -32768, OVF=1.
// - KEY_INC and KEY_DEC rise same cycle with DIG_SEL=1 -> OUT=+10 only.
//   - DIG_SEL=7 INC -> OUT unchanged, no CHANGED.
//   - RST_N low during REPEAT -> OUT=0 immediately.

Source files
------------

// File: rtl/num_pkg.sv
// num_pkg: shared state/key types and constant helpers for the number-entry block.
package num_pkg;

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT, WAIT_REL} entry_state_t;

    // Action chosen from the keys; K_NONE when no key is pressed.
    typedef enum logic [2:0] {K_NONE, K_INC, K_DEC, K_NEG, K_CLR, K_LOAD} key_code_t;

    // Bit positions of the keys inside the synchronised key vector.
    localparam int KEY_N   = 5;
    localparam int KB_INC  = 0;
    localparam int KB_DEC  = 1;
    localparam int KB_NEG  = 2;
    localparam int KB_CLR  = 3;
    localparam int KB_LOAD = 4;

    // Largest value of a bits-wide two's-complement number.
    function automatic longint max_val(input int bits);
        return (longint'(1) <<< (bits - 1)) - 1;
    endfunction

    // Smallest value of a bits-wide two's-complement number.
    function automatic longint min_val(input int bits);
        return -(longint'(1) <<< (bits - 1));
    endfunction

    // 10^k, or 0 when it cannot be represented as a positive bits-wide step.
    function automatic longint pow10(input int k, input int bits);
        longint p;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return (p <= max_val(bits)) ? p : longint'(0);
    endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for a vector of asynchronous level inputs.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Shift the raw level through two flops; the first may go metastable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking so both stages sample pre-edge values and form a real 2-stage chain.
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/num_entry_seq.sv
// num_entry_seq: key-driven signed operand register with single-action-per-press,
// hold-to-auto-repeat and saturating or wrapping overflow with a sticky flag.
module num_entry_seq
    import num_pkg::*;
#(
    parameter int BITS     = 16,
    parameter int DIGITS   = 5,
    parameter int SAT      = 1,
    parameter int HOLD_CYC = 25000000,
    parameter int REP_CYC  = 5000000,
    localparam int SEL_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             KEY_INC,
    input  logic             KEY_DEC,
    input  logic             KEY_NEG,
    input  logic             CLR,
    input  logic             LOAD,
    input  logic [BITS-1:0]  LOAD_VAL,
    input  logic [SEL_W-1:0] DIG_SEL,
    output logic [BITS-1:0]  OUT,
    output logic             CHANGED,
    output logic             OVF
);

    localparam int CNT_MAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LOAD  = CNT_W'(REP_CYC - 1);
    localparam logic [BITS-1:0]  MAX_V     = BITS'(max_val(BITS));
    localparam logic [BITS-1:0]  MIN_V     = BITS'(min_val(BITS));

    if (pow10(DIGITS - 1, BITS) == 0) begin : g_bad_digits
        $error("num_entry_seq: 10^(DIGITS-1) must be below 2^(BITS-1)");
    end

    // Reset: asynchronous assertion, release aligned to CLK.
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    // Two-flop reset release so all state leaves reset on the same edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

    // Key synchronisation.
    logic [KEY_N-1:0] key_raw;
    logic [KEY_N-1:0] key_s;

    assign key_raw = {LOAD, CLR, KEY_NEG, KEY_DEC, KEY_INC};

    sync2 #(.WIDTH(KEY_N)) u_key_sync (
        .clk   (CLK),
        .rst_n (RST_N),
        .d_i   (key_raw),
        .q_o   (key_s)
    );

    // Step table 10^k, k = 0..DIGITS-1.
    logic [BITS-1:0] step_tab [DIGITS];
    for (genvar g = 0; g < DIGITS; g++) begin : g_step
        assign step_tab[g] = BITS'(pow10(g, BITS));
    end

    // Registered state.
    entry_state_t    state_q;
    key_code_t       key_q;
    logic [CNT_W-1:0] cnt_q;
    logic [BITS-1:0] out_q;
    logic            changed_q;
    logic            ovf_q;

    // Combinational decode.
    key_code_t         win_key;
    key_code_t         act_key;
    logic              key_held;
    logic              fire;
    logic [BITS-1:0]   step;
    logic signed [BITS:0] cur_x;
    logic signed [BITS:0] step_x;
    logic signed [BITS:0] sum_x;
    logic              range_ovf;
    logic [BITS-1:0]   fit_val;
    logic [BITS-1:0]   new_val;
    logic              do_write;
    logic              ovf_set;
    logic              ovf_clr;

    // Fixed priority among keys seen together in IDLE: LOAD > CLR > NEG > INC > DEC.
    always_comb begin
        // NOTE: default first so every path assigns win_key and no latch is inferred.
        win_key = K_NONE;
        if      (key_s[KB_LOAD]) win_key = K_LOAD;
        else if (key_s[KB_CLR])  win_key = K_CLR;
        else if (key_s[KB_NEG])  win_key = K_NEG;
        else if (key_s[KB_INC])  win_key = K_INC;
        else if (key_s[KB_DEC])  win_key = K_DEC;
    end

    // Level of the key that owns the current hold/repeat.
    always_comb begin
        key_held = 1'b0;
        case (key_q)
            K_INC:   key_held = key_s[KB_INC];
            K_DEC:   key_held = key_s[KB_DEC];
            default: key_held = 1'b0;
        endcase
    end

    // Decide whether this cycle is an action cycle and which action it applies.
    always_comb begin
        fire    = 1'b0;
        act_key = key_q;
        case (state_q)
            IDLE: begin
                act_key = win_key;
                fire    = (win_key != K_NONE);
            end
            HOLD, REPEAT: fire = key_held && (cnt_q == '0);
            default:      fire = 1'b0;
        endcase
    end

    // Step lookup; exponents beyond the table give a zero step.
    always_comb begin
        step = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (int'(DIG_SEL) == k) step = step_tab[k];
        end
    end

    // One extra bit of headroom, then range-check and clamp or wrap.
    always_comb begin
        cur_x  = {out_q[BITS-1], out_q};
        step_x = {1'b0, step};
        case (act_key)
            K_INC:   sum_x = cur_x + step_x;
            K_DEC:   sum_x = cur_x - step_x;
            K_NEG:   sum_x = -cur_x;
            default: sum_x = cur_x;
        endcase
        range_ovf = sum_x[BITS] ^ sum_x[BITS-1];
        if (range_ovf && (SAT != 0)) fit_val = sum_x[BITS] ? MIN_V : MAX_V;
        else                         fit_val = sum_x[BITS-1:0];
    end

    // Effect of the selected action on the value and the overflow flag.
    always_comb begin
        new_val  = fit_val;
        do_write = 1'b0;
        ovf_set  = 1'b0;
        ovf_clr  = 1'b0;
        case (act_key)
            K_INC, K_DEC: begin
                do_write = (step != '0);
                ovf_set  = (step != '0) && range_ovf;
            end
            K_NEG: begin
                do_write = 1'b1;
                ovf_set  = range_ovf;
            end
            K_CLR: begin
                new_val  = '0;
                do_write = 1'b1;
                ovf_clr  = 1'b1;
            end
            K_LOAD: begin
                new_val  = LOAD_VAL;
                do_write = 1'b1;
                ovf_clr  = 1'b1;
            end
            default: ;
        endcase
    end

    // Entry FSM with repeat counter and registered value/pulse/flag outputs.
    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q   <= WAIT_REL;
            key_q     <= K_NONE;
            cnt_q     <= '0;
            out_q     <= '0;
            changed_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            changed_q <= 1'b0;
            if (fire) begin
                if (do_write) begin
                    out_q     <= new_val;
                    changed_q <= 1'b1;
                end
                if (ovf_clr)      ovf_q <= 1'b0;
                else if (ovf_set) ovf_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (win_key != K_NONE) begin
                        key_q <= win_key;
                        if (win_key == K_INC || win_key == K_DEC) begin
                            state_q <= HOLD;
                            cnt_q   <= HOLD_LOAD;
                        end else begin
                            state_q <= WAIT_REL;
                            cnt_q   <= '0;
                        end
                    end
                end
                HOLD, REPEAT: begin
                    if (!key_held) begin
                        state_q <= WAIT_REL;
                        cnt_q   <= '0;
                    end else if (cnt_q == '0) begin
                        state_q <= REPEAT;
                        cnt_q   <= REP_LOAD;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                WAIT_REL: begin
                    if (key_s == '0) state_q <= IDLE;
                end
                default: state_q <= WAIT_REL;
            endcase
        end
    end

    assign OUT     = out_q;
    assign CHANGED = changed_q;
    assign OVF     = ovf_q;

endmodule

// File: tb/tb_num_entry_seq.sv
// tb_num_entry_seq: scoreboard bench; a saturating and a wrapping instance share stimulus.
module tb_num_entry_seq;

    localparam int BITS     = 16;
    localparam int DIGITS   = 5;
    localparam int HOLD_CYC = 4;
    localparam int REP_CYC  = 2;
    localparam int VMAX     = 32767;
    localparam int VMIN     = -32768;

    localparam int A_INC  = 0;
    localparam int A_DEC  = 1;
    localparam int A_NEG  = 2;
    localparam int A_CLR  = 3;
    localparam int A_LOAD = 4;

    typedef struct {
        int cyc;
        int val;
        int ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_inc, key_dec, key_neg, clr, load;
    logic [15:0] load_val;
    logic [2:0]  dig_sel;
    logic [15:0] out_s, out_w;
    logic        chg_s, chg_w, ovf_s, ovf_w;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    exp_t q_s[$];
    exp_t q_w[$];
    int   mv_s = 0, mv_w = 0;
    int   mo_s = 0, mo_w = 0;

    num_entry_seq #(.BITS(BITS), .DIGITS(DIGITS), .SAT(1), .HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_dut_sat (
        .CLK(clk), .RST_N(rst_n), .KEY_INC(key_inc), .KEY_DEC(key_dec), .KEY_NEG(key_neg),
        .CLR(clr), .LOAD(load), .LOAD_VAL(load_val), .DIG_SEL(dig_sel),
        .OUT(out_s), .CHANGED(chg_s), .OVF(ovf_s)
    );

    num_entry_seq #(.BITS(BITS), .DIGITS(DIGITS), .SAT(0), .HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_dut_wrap (
        .CLK(clk), .RST_N(rst_n), .KEY_INC(key_inc), .KEY_DEC(key_dec), .KEY_NEG(key_neg),
        .CLR(clr), .LOAD(load), .LOAD_VAL(load_val), .DIG_SEL(dig_sel),
        .OUT(out_w), .CHANGED(chg_w), .OVF(ovf_w)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input integer act, input integer exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ideal result of an action on value v, before range handling.
    function automatic int raw_result(input int a, input int v, input int step, input int lval);
        case (a)
            A_INC:   return v + step;
            A_DEC:   return v - step;
            A_NEG:   return -v;
            A_CLR:   return 0;
            default: return lval;
        endcase
    endfunction

    // Apply one action to both reference values and queue the expected CHANGED cycle.
    task automatic model_act(input int a, input int dig, input int lval, input int when);
        int   step;
        int   r;
        exp_t e;
        if ((a == A_INC || a == A_DEC) && dig >= DIGITS) return;
        step = 1;
        for (int i = 0; i < dig; i++) step = step * 10;
        if (a == A_CLR || a == A_LOAD) begin
            mo_s = 0;
            mo_w = 0;
        end
        r = raw_result(a, mv_s, step, lval);
        if (r > VMAX)      begin r = VMAX; mo_s = 1; end
        else if (r < VMIN) begin r = VMIN; mo_s = 1; end
        mv_s = r;
        e.cyc = when; e.val = mv_s; e.ovf = mo_s;
        q_s.push_back(e);
        r = raw_result(a, mv_w, step, lval);
        if (r > VMAX)      begin r = r - 65536; mo_w = 1; end
        else if (r < VMIN) begin r = r + 65536; mo_w = 1; end
        mv_w = r;
        e.cyc = when; e.val = mv_w; e.ovf = mo_w;
        q_w.push_back(e);
    endtask

    function automatic int winner(input logic [4:0] m);
        if (m[4]) return A_LOAD;
        if (m[3]) return A_CLR;
        if (m[2]) return A_NEG;
        if (m[0]) return A_INC;
        if (m[1]) return A_DEC;
        return -1;
    endfunction

    // Hold keys (mask = {LOAD,CLR,NEG,DEC,INC}) for len cycles, release, let the DUT settle.
    task automatic press(input logic [4:0] mask, input int len, input int dig, input int lval);
        int n0;
        int w;
        @(negedge clk);
        dig_sel  = 3'(dig);
        load_val = 16'(lval);
        {load, clr, key_neg, key_dec, key_inc} = mask;
        n0 = cyc;
        w  = winner(mask);
        if (w >= 0) begin
            model_act(w, dig, lval, n0 + 3);
            if (w == A_INC || w == A_DEC) begin
                for (int off = HOLD_CYC; off <= len - 1; off += REP_CYC)
                    model_act(w, dig, lval, n0 + 3 + off);
            end
        end
        repeat (len) @(negedge clk);
        {load, clr, key_neg, key_dec, key_inc} = 5'b0;
        repeat (8) @(negedge clk);
        check("drain_sat", q_s.size(), 0);
        check("drain_wrap", q_w.size(), 0);
        check("out_sat", $signed(out_s), mv_s);
        check("out_wrap", $signed(out_w), mv_w);
        check("ovf_sat", ovf_s, mo_s);
        check("ovf_wrap", ovf_w, mo_w);
    endtask

    task automatic sb_pop(input bit is_sat, input integer v, input integer o);
        exp_t e;
        if (is_sat) begin
            if (q_s.size() == 0) begin
                check("sat_unexpected_changed", 1, 0);
                return;
            end
            e = q_s.pop_front();
            check("sat_chg_cycle", cyc, e.cyc);
            check("sat_chg_out", v, e.val);
            check("sat_chg_ovf", o, e.ovf);
        end else begin
            if (q_w.size() == 0) begin
                check("wrap_unexpected_changed", 1, 0);
                return;
            end
            e = q_w.pop_front();
            check("wrap_chg_cycle", cyc, e.cyc);
            check("wrap_chg_out", v, e.val);
            check("wrap_chg_ovf", o, e.ovf);
        end
    endtask

    // Monitor: pops the scoreboard whenever either DUT reports a write.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (chg_s !== 1'b0) sb_pop(1'b1, $signed(out_s), ovf_s);
            if (chg_w !== 1'b0) sb_pop(1'b0, $signed(out_w), ovf_w);
        end
    end

    initial begin
        int n0;
        int sel;
        int dig;
        int len;
        int lval;
        logic [4:0] m;

        rst_n    = 1'b0;
        {load, clr, key_neg, key_dec, key_inc} = 5'b0;
        load_val = '0;
        dig_sel  = '0;

        // Reset values.
        @(negedge clk);
        check("rst_out", out_s, 0);
        check("rst_chg", chg_s, 0);
        check("rst_ovf", ovf_s, 0);
        check("rst_out_wrap", out_w, 0);

        // KEY_INC held across reset release does nothing until released.
        key_inc = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("held_thru_reset", $signed(out_s), 0);
        key_inc = 1'b0;
        repeat (8) @(negedge clk);
        check("held_thru_reset_rel", $signed(out_s), 0);

        // Single press, DIG_SEL=2: +100 three clocks after the rise.
        press(5'b00001, 3, 2, 0);
        // CLR, then a 12-cycle hold with auto-repeat: five steps of 1.
        press(5'b01000, 1, 0, 0);
        press(5'b00001, 12, 0, 0);
        check("repeat_out", $signed(out_s), 5);

        // Positive overflow from 32760 with +10.
        press(5'b10000, 1, 0, 32760);
        press(5'b00001, 1, 1, 0);
        check("posovf_sat", $signed(out_s), 32767);
        check("posovf_wrap", $signed(out_w), -32766);
        press(5'b01000, 1, 0, 0);

        // Negating MIN.
        press(5'b10000, 1, 0, -32768);
        press(5'b00100, 1, 0, 0);
        check("negmin_sat", $signed(out_s), 32767);
        check("negmin_wrap", $signed(out_w), -32768);

        // Negative overflow with -10000.
        press(5'b10000, 2, 0, -30000);
        press(5'b00010, 1, 4, 0);

        // Simultaneous INC and DEC: INC wins.
        press(5'b01000, 1, 0, 0);
        press(5'b00011, 2, 1, 0);
        check("inc_dec_tie", $signed(out_s), 10);

        // Out-of-range exponent: no write at all.
        press(5'b00001, 3, 7, 0);
        press(5'b00010, 6, 5, 0);

        // Reset asserted during REPEAT clears immediately.
        @(negedge clk);
        dig_sel = 3'd0;
        key_inc = 1'b1;
        n0 = cyc;
        model_act(A_INC, 0, 0, n0 + 3);
        model_act(A_INC, 0, 0, n0 + 3 + HOLD_CYC);
        model_act(A_INC, 0, 0, n0 + 3 + HOLD_CYC + REP_CYC);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrep_rst_out", $signed(out_s), 0);
        check("midrep_rst_out_wrap", $signed(out_w), 0);
        check("midrep_rst_chg", chg_s, 0);
        mv_s = 0; mv_w = 0; mo_s = 0; mo_w = 0;
        key_inc = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("midrep_drain", q_s.size() + q_w.size(), 0);
        check("midrep_after", $signed(out_s), 0);

        // Randomised presses.
        for (int t = 0; t < 40; t++) begin
            sel  = int'($urandom_range(0, 9));
            dig  = int'($urandom_range(0, 7));
            len  = int'($urandom_range(1, 11));
            lval = int'($urandom_range(0, 65535)) - 32768;
            case (sel)
                0, 1, 2, 3: m = 5'b00001;
                4, 5:       m = 5'b00010;
                6:          m = 5'b00100;
                7:          m = 5'b10000;
                8:          m = 5'b01000;
                default:    m = 5'($urandom_range(1, 31));
            endcase
            press(m, len, dig, lval);
        end

        repeat (4) @(negedge clk);
        check("final_drain", q_s.size() + q_w.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
